port_queue_reader: RTL
======================

// Module: port_queue_reader
// PURPOSE
// Per-port egress queue reader; the counterpart of port_rd_dispatch on the dispatch interface.
// Tracks packet count and per-packet beat length for 8 priority queues and drives
// queue_empty to the dispatcher. Serves the queue named by rd_prior, streaming the
// head packet's beats downstream, then pulses update once per packet served.
// PARAMETERS
// PKT_DEPTH  32  max packets held per queue (length ring depth); power of two
// LEN_W      6   packet length field width, in beats
// CNT_W      6   per-queue count width; must satisfy 2**CNT_W > PKT_DEPTH
// PORTS
// clk          in   1      clock
// rst_n        in   1      asynchronous active-low reset
// wr_pkt_valid in   1      one-cycle pulse: a complete packet was written to a queue
// wr_pkt_prior in   3      target queue of the written packet
// wr_pkt_len   in   LEN_W  packet length in beats; 0 is treated as 1
// wr_drop      out  1      one-cycle pulse: enqueue rejected because the queue is full
// queue_empty  out  8      per-queue empty flags to the dispatcher
// rd_prior     in   4      queue selected by the dispatcher; 8..15 = none
// update       out  1      one-cycle pulse: one packet of rd_prior's queue fully served
// out_valid    out  1      downstream beat valid
// out_queue    out  3      queue of the current beat
// out_last     out  1      current beat is the packet's final beat
// out_ready    in   1      downstream accepts the beat when out_valid && out_ready
// BEHAVIOUR
// - Reset values: queue_empty=8'hFF; update, wr_drop, out_valid, out_last = 0; out_queue = 0; counts 0; FSM in IDLE.
// - Enqueue: on wr_pkt_valid, if count[q] < PKT_DEPTH, write len to ring[q] at wr_ptr[q], advance wr_ptr[q],
//   count[q] += 1. Otherwise nothing is written and wr_drop pulses on the next cycle.
// - queue_empty[q] is registered from count[q] == 0, so it lags the count by one cycle.
// - Same-cycle enqueue and dequeue on one queue leaves count unchanged; the ring pointers both advance.
// - FSM states: IDLE -> LOAD -> SEND -> DONE -> GAP -> IDLE.
// - IDLE: if rd_prior[3]==0 && count[rd_prior[2:0]] != 0, latch cur_q = rd_prior[2:0] and go to LOAD. Otherwise stay.
// - LOAD: read ring[cur_q] at rd_ptr[cur_q] into beat_left (0 becomes 1), then go to SEND.
// - SEND: out_valid=1, out_queue=cur_q, out_last=(beat_left==1).
//   - On out_valid && out_ready, beat_left decrements.
//   - When the last beat is accepted, go to DONE.
//   - out_valid stays high while out_ready is low; no beat is skipped or repeated.
// - DONE: update=1 for exactly this cycle; advance rd_ptr[cur_q]; count[cur_q] -= 1; go to GAP.
// - GAP: one idle cycle so queue_empty and rd_prior settle before the next selection.
// - Latency: rd_prior valid in IDLE to first out_valid = 2 cycles. Minimum per-packet period = len + 4 cycles.
// - rd_prior changes during LOAD/SEND are ignored; cur_q is held until DONE.
// - Pointers wrap modulo PKT_DEPTH. Counts never underflow: DONE is reachable only with count != 0.
// - Asynchronous reset mid-packet: out_valid drops immediately; all queued packets are discarded.
// CONFIGURATION
// - PORT_RD_DROP_CNT_EN defined:
//   - adds output drop_cnt [7:0][15:0]: per-queue count of rejected enqueues.
//   - counters saturate at 16'hFFFF; reset value 0.
// - PORT_RD_DROP_CNT_EN undefined: no drop_cnt port and no counters. wr_drop still pulses.
// TESTING
// - Enqueue q2 len 3, rd_prior=2, out_ready=1
//   -> queue_empty[2] falls 1 cycle after enqueue; 3 beats on out_queue=2 with out_last on the 3rd;
//      one update pulse; queue_empty[2] returns to 1.
// - rd_prior=8 with all queues non-empty -> out_valid stays 0 and update stays 0 indefinitely.
// - 33 enqueues to q5 with PKT_DEPTH=32 -> the 33rd enqueue pulses wr_drop; count stays 32;
//   with PORT_RD_DROP_CNT_EN, drop_cnt[5]=1.
// - Enqueue q0 len 0 -> exactly one beat, with out_last=1.
// - Serving q1 len 4 with out_ready toggling 1,0,1,0
//   -> exactly 4 accepted beats; out_valid never drops mid-packet; update asserted after the 4th accept.
// - Enqueue to q3 in the same cycle as q3's DONE with count 1
//   -> count stays 1 and queue_empty[3] stays 0; the next packet is served with the newly written length.
// - Assert rst_n=0 during SEND
//   -> out_valid=0 immediately; after release queue_empty=8'hFF and no update pulse.

Source files
------------

// File: rtl/port_queue_reader.sv
// ---------------------------------------------------------------------------
// port_queue_reader
//   Per-port egress queue reader. Keeps a packet count and a ring of packet
//   lengths (in beats) for each of 8 priority queues, reports per-queue empty
//   flags to the dispatcher, streams the head packet of the queue chosen by
//   rd_prior downstream, and pulses update once per packet served.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_pkt_valid/prior/len  packet-written notification (len 0 counts as 1)
//   wr_drop               one-cycle pulse after an enqueue to a full queue
//   queue_empty[7:0]      registered per-queue empty flags
//   rd_prior[3:0]         dispatcher selection, 8..15 = no selection
//   update                one-cycle pulse when a packet has been fully served
//   out_valid/out_queue/out_last/out_ready  downstream beat handshake
//   drop_cnt[7:0][15:0]   saturating per-queue drop counters (optional)
//
// Build option
//   PORT_RD_DROP_CNT_EN   when defined, adds the drop_cnt output and counters.
//
// FSM: IDLE -> LOAD -> SEND -> DONE -> GAP -> IDLE
// ---------------------------------------------------------------------------
module port_queue_reader #(
   parameter int PKT_DEPTH = 32,
   parameter int LEN_W     = 6,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_pkt_valid,
   input  logic [2:0]       wr_pkt_prior,
   input  logic [LEN_W-1:0] wr_pkt_len,
   output logic             wr_drop,
   output logic [7:0]       queue_empty,
   input  logic [3:0]       rd_prior,
   output logic             update,
   output logic             out_valid,
   output logic [2:0]       out_queue,
   output logic             out_last,
   input  logic             out_ready
`ifdef PORT_RD_DROP_CNT_EN
   ,
   output logic [7:0][15:0] drop_cnt
`endif
);

   localparam int PW = $clog2(PKT_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(PKT_DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   logic [2:0]       state;
   logic [2:0]       cur_q;
   logic [LEN_W-1:0] beat_left;
   logic [CNT_W-1:0] count  [8];
   logic [PW-1:0]    wr_ptr [8];
   logic [PW-1:0]    rd_ptr [8];
   logic [LEN_W-1:0] ring   [8][PKT_DEPTH];

   logic             enq_ok;
   logic             deq;
   logic [LEN_W-1:0] head_len;

   assign enq_ok   = wr_pkt_valid && (count[wr_pkt_prior] < DEPTH);
   assign deq      = (state == S_DONE);
   assign head_len = ring[cur_q][rd_ptr[cur_q]];

   // Length storage carries no reset: only pointers/counts define validity.
   always_ff @(posedge clk) begin
      if (enq_ok)
         ring[wr_pkt_prior][wr_ptr[wr_pkt_prior]] <= wr_pkt_len;
   end

   // Per-queue bookkeeping. Simultaneous enqueue and dequeue on one queue
   // moves both pointers but leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < 8; q++) begin
            count[q]  <= '0;
            wr_ptr[q] <= '0;
            rd_ptr[q] <= '0;
         end
         queue_empty <= 8'hFF;
         wr_drop     <= 1'b0;
      end else begin
         for (int q = 0; q < 8; q++) begin
            if (enq_ok && wr_pkt_prior == 3'(q))
               wr_ptr[q] <= wr_ptr[q] + PW'(1);
            if (deq && cur_q == 3'(q))
               rd_ptr[q] <= rd_ptr[q] + PW'(1);
            if ((enq_ok && wr_pkt_prior == 3'(q)) && !(deq && cur_q == 3'(q)))
               count[q] <= count[q] + CNT_W'(1);
            else if (!(enq_ok && wr_pkt_prior == 3'(q)) && (deq && cur_q == 3'(q)))
               count[q] <= count[q] - CNT_W'(1);
            // Registered from the current count, so it trails the count by a cycle.
            queue_empty[q] <= (count[q] == '0);
         end
         wr_drop <= wr_pkt_valid && !enq_ok;
      end
   end

   // Serving FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cur_q <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rd_prior[3] && count[rd_prior[2:0]] != '0) begin
                  cur_q <= rd_prior[2:0];
                  state <= S_LOAD;
               end
            end
            S_LOAD:  state <= S_SEND;
            S_SEND: begin
               if (out_ready && beat_left == LEN_W'(1))
                  state <= S_DONE;
            end
            S_DONE:  state <= S_GAP;
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Beat counter; a stored length of 0 is served as a single beat.
   always_ff @(posedge clk) begin
      if (state == S_LOAD)
         beat_left <= (head_len == '0) ? LEN_W'(1) : head_len;
      else if (state == S_SEND && out_ready)
         beat_left <= beat_left - LEN_W'(1);
   end

   assign out_valid = (state == S_SEND);
   assign out_queue = cur_q;
   assign out_last  = out_valid && (beat_left == LEN_W'(1));
   assign update    = (state == S_DONE);

`ifdef PORT_RD_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (wr_pkt_valid && !enq_ok && drop_cnt[wr_pkt_prior] != 16'hFFFF) begin
         drop_cnt[wr_pkt_prior] <= drop_cnt[wr_pkt_prior] + 16'd1;
      end
   end
`endif

endmodule
